// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the shared memory port.
// slave is the arbiter's view; master is the view of the surrounding requesters and memory.
interface mem_arbiter_if;
  logic        instr_req_ip;
  logic [31:0] instr_addr_ip;
  logic        instr_gnt_op;
  logic        instr_rvalid_op;

  logic        data_req_ip;
  logic        data_we_ip;
  logic [3:0]  data_be_ip;
  logic [31:0] data_addr_ip;
  logic [31:0] data_wdata_ip;
  logic        data_gnt_op;
  logic        data_rvalid_op;

  logic        mem_req_op;
  logic        mem_we_op;
  logic [3:0]  mem_be_op;
  logic [31:0] mem_addr_op;
  logic [31:0] mem_wdata_op;
  logic        mem_gnt_ip;
  logic        mem_rvalid_ip;
  logic [31:0] mem_rdata_ip;

  logic [31:0] rdata_op;
  logic        timeout_err_op;

  modport slave (
    input  instr_req_ip, instr_addr_ip,
    output instr_gnt_op, instr_rvalid_op,
    input  data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
    output data_gnt_op, data_rvalid_op,
    output mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
    input  mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
    output rdata_op, timeout_err_op
  );

  modport master (
    output instr_req_ip, instr_addr_ip,
    input  instr_gnt_op, instr_rvalid_op,
    output data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
    input  data_gnt_op, data_rvalid_op,
    input  mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
    output mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
    input  rdata_op, timeout_err_op
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction fetch and a load/store
// requester, with a single outstanding transaction and a response timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_PRE = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic OWNER_INSTR = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e           state_q, state_d;
  logic             owner_q, last_owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             any_req, pick_data, arb_en, win, timeout_hit, resp_fire;

  // Round-robin choice: a lone requester wins, contention goes to the one that did not win last.
  always_comb begin : arbitration
    any_req     = bus.instr_req_ip | bus.data_req_ip;
    pick_data   = bus.data_req_ip & (~bus.instr_req_ip | (last_owner_q == OWNER_INSTR));
    arb_en      = (state_q == IDLE) | ((state_q == RESP) & bus.mem_rvalid_ip);
    win         = arb_en & any_req;
    timeout_hit = (state_q == RESP) & ~bus.mem_rvalid_ip & (cnt_q == TIMEOUT_VAL);
  end

  always_ff @(posedge clock) begin : state_reg
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE: if (any_req) state_d = REQ;
      REQ:  if (bus.mem_gnt_ip) state_d = RESP;
      RESP: begin
        if (bus.mem_rvalid_ip) state_d = any_req ? REQ : IDLE;
        else if (timeout_hit)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A timed-out response still completes toward the owner so it never stalls forever.
  always_comb begin : outputs
    bus.instr_gnt_op    = 1'b0;
    bus.data_gnt_op     = 1'b0;
    bus.instr_rvalid_op = 1'b0;
    bus.data_rvalid_op  = 1'b0;
    bus.rdata_op        = bus.mem_rdata_ip;
    resp_fire           = (state_q == RESP) & (bus.mem_rvalid_ip | timeout_hit);
    if ((state_q == REQ) & bus.mem_gnt_ip & bus.mem_req_op) begin
      bus.instr_gnt_op = (owner_q == OWNER_INSTR);
      bus.data_gnt_op  = (owner_q == OWNER_DATA);
    end
    if (resp_fire) begin
      bus.instr_rvalid_op = (owner_q == OWNER_INSTR);
      bus.data_rvalid_op  = (owner_q == OWNER_DATA);
    end
  end

  always_ff @(posedge clock) begin : datapath
    if (reset) begin
      bus.mem_req_op     <= 1'b0;
      bus.mem_we_op      <= 1'b0;
      bus.mem_be_op      <= 4'h0;
      bus.mem_addr_op    <= 32'h0;
      bus.mem_wdata_op   <= 32'h0;
      bus.timeout_err_op <= 1'b0;
      owner_q            <= OWNER_INSTR;
      last_owner_q       <= OWNER_DATA;
      cnt_q              <= '0;
    end else begin
      bus.mem_req_op <= (state_d == REQ);
      if (win) begin
        owner_q      <= pick_data;
        last_owner_q <= pick_data;
        if (pick_data) begin
          bus.mem_we_op    <= bus.data_we_ip;
          bus.mem_be_op    <= bus.data_be_ip;
          bus.mem_addr_op  <= bus.data_addr_ip;
          bus.mem_wdata_op <= bus.data_wdata_ip;
        end else begin
          bus.mem_we_op    <= 1'b0;
          bus.mem_be_op    <= 4'hF;
          bus.mem_addr_op  <= bus.instr_addr_ip;
          bus.mem_wdata_op <= 32'h0;
        end
      end
      // Counter saturates at the limit; the flag is raised as the limit is reached.
      if ((state_q == REQ) & bus.mem_gnt_ip)
        cnt_q <= '0;
      else if ((state_q == RESP) & ~bus.mem_rvalid_ip & (cnt_q != TIMEOUT_VAL))
        cnt_q <= cnt_q + CNT_W'(1);
      if ((state_q == RESP) & ~bus.mem_rvalid_ip & (cnt_q == TIMEOUT_PRE))
        bus.timeout_err_op <= 1'b1;
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 255, the maximum number of cycles spent in RESP before aborting (range 1..255).
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 instr_req_ip  input  1  instruction fetch request; held until instr_gnt_op.
REQ-005 instr_addr_ip  input  32  fetch byte address.
REQ-006 instr_gnt_op  output  1  fetch request accepted by memory.
REQ-007 instr_rvalid_op  output  1  rdata_op holds the fetch response.
REQ-008 data_req_ip  input  1  load/store request; held until data_gnt_op.
REQ-009 data_we_ip  input  1  1 = store, 0 = load.
REQ-010 data_be_ip  input  4  store byte enables.
REQ-011 data_addr_ip  input  32  load/store byte address.
REQ-012 data_wdata_ip  input  32  store data.
REQ-013 data_gnt_op  output  1  load/store accepted by memory.
REQ-014 data_rvalid_op  output  1  load/store response (store acknowledge included).
REQ-015 mem_req_op  output  1  registered request to the shared memory port.
REQ-016 mem_we_op  output  1  registered write enable; 0 for fetches.
REQ-017 mem_be_op  output  4  registered byte enables; 4'hF for fetches.
REQ-018 mem_addr_op  output  32  registered request address.
REQ-019 mem_wdata_op  output  32  registered write data; 0 for fetches.
REQ-020 mem_gnt_ip  input  1  memory accepts the current mem_req_op.
REQ-021 mem_rvalid_ip  input  1  memory response valid (reads and writes).
REQ-022 mem_rdata_ip  input  32  memory read data.
REQ-023 rdata_op  output  32  combinational copy of mem_rdata_ip, shared by both requesters.
REQ-024 timeout_err_op  output  1  sticky flag set when a response times out.

Function
REQ-025 The FSM SHALL have states IDLE, REQ and RESP; at most one transaction is outstanding.
REQ-026 Arbitration SHALL occur in IDLE, and in RESP on the mem_rvalid_ip cycle; the winner's request fields SHALL be latched into the mem_*_op registers and owner set; next state is REQ, or IDLE if no request is pending.
REQ-027 If only one requester is pending, it wins; if both are pending, the requester not equal to last_owner wins (round-robin); last_owner updates on every win.
REQ-028 In REQ, mem_req_op SHALL be 1 with stable fields until mem_gnt_ip=1; on that cycle the owner's gnt output is 1 (combinational: mem_gnt_ip & mem_req_op & owner match); next state is RESP, with mem_req_op=0 from the following cycle.
REQ-029 In RESP, the owner's rvalid output SHALL equal mem_rvalid_ip; in IDLE and REQ, both rvalid outputs are 0 and mem_rvalid_ip is ignored.
REQ-030 A gnt output SHALL never be asserted to a non-owner; gnt and rvalid are never high for both requesters in the same cycle.
REQ-031 A requester SHALL deassert req or present a new request the cycle after its gnt; req is not sampled in REQ, nor in RESP before mem_rvalid_ip.
REQ-032 Latency from req (IDLE) to mem_req_op SHALL be 1 cycle; the minimum issue-to-issue gap is 3 cycles (REQ, RESP with rvalid, REQ).
REQ-033 A cycle counter SHALL clear on RESP entry and increment each RESP cycle without rvalid; on reaching TIMEOUT_CYCLES: set timeout_err_op, pulse the owner's rvalid for 1 cycle with rdata_op = mem_rdata_ip, then go to IDLE.
REQ-034 A mem_gnt_ip pulse outside REQ SHALL be ignored.

Reset
REQ-035 reset SHALL force state=IDLE, mem_req_op=0, mem_we_op=0, mem_be_op=0, mem_addr_op=0, mem_wdata_op=0, timeout_err_op=0, counter=0 and last_owner=DATA (so the first contended win goes to instr), overriding any in-flight transaction; a late mem_rvalid_ip after reset produces no rvalid output.

Verification
REQ-036 Single fetch: instr_req_ip=1, addr 0x40 at cycle N -> mem_req_op=1, mem_addr_op=0x40, mem_be_op=4'hF at N+1; mem_gnt_ip at N+1 -> instr_gnt_op=1 at N+1; mem_rvalid_ip at N+3, rdata 0xDEADBEEF -> instr_rvalid_op=1, rdata_op=0xDEADBEEF.
REQ-037 Contention after reset: both requesters pending -> instr wins first; on its rvalid cycle data wins next with mem_we_op/mem_be_op/mem_wdata_op matching the data inputs.
REQ-038 Store: data_we_ip=1, be=4'b0011, wdata 0x1234 -> mem_we_op=1, mem_be_op=4'b0011, mem_wdata_op=0x1234; the ack rvalid goes to data_rvalid_op only.
REQ-039 Timeout with TIMEOUT_CYCLES=4 and no rvalid -> timeout_err_op=1 and the owner's rvalid pulses after 4 RESP cycles; state IDLE; the flag stays 1 until reset.
REQ-040 Reset mid-RESP, followed by mem_rvalid_ip -> no rvalid outputs, mem_req_op=0, and the next request is served normally.
